// File: rtl/instr_sequencer_if.sv
// Bus bundle between the Aardvark control sequencer and its datapath/memories.
// master = sequencer side, slave = datapath/memory side.
// Optional SEQ_PERF_CNT_EN adds the retired-instruction counter signal.
interface instr_sequencer_if;
  logic       run;
  logic       imem_req;
  logic       imem_ready;
  logic [7:0] imem_rdata;
  logic [7:0] instr_out;
  logic       ir_load;
  logic       alu_en;
  logic       alu_zero;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ready;
  logic       reg_write;
  logic       pc_inc;
  logic       pc_load;
  logic       fault;
  logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0] retired_cnt;
`endif

  modport master (
    input  run, imem_ready, imem_rdata, alu_zero, dmem_ready,
    output imem_req, instr_out, ir_load, alu_en, dmem_req, dmem_we,
           reg_write, pc_inc, pc_load, fault, state
`ifdef SEQ_PERF_CNT_EN
    , output retired_cnt
`endif
  );

  modport slave (
    output run, imem_ready, imem_rdata, alu_zero, dmem_ready,
    input  imem_req, instr_out, ir_load, alu_en, dmem_req, dmem_we,
           reg_write, pc_inc, pc_load, fault, state
`ifdef SEQ_PERF_CNT_EN
    , input retired_cnt
`endif
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 8-bit Aardvark core.
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) with one-cycle control pulses,
// handshake timeout detection and a sticky FAULT state.
// Optional feature macro: SEQ_PERF_CNT_EN (16-bit retired-instruction counter).
module instr_sequencer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TW             = 4
) (
  input logic               clk,
  input logic               reset_n,
  instr_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  // The wait that would make the count reach TIMEOUT_CYCLES is the last one allowed.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [7:0]    instr_reg;
  logic [TW-1:0] tmo_reg;
  logic          fault_reg;

  logic imem_req, ir_load, alu_en, dmem_req, dmem_we;
  logic reg_write, pc_inc, pc_load;

  // Opcode class, taken from the latched instruction.
  logic is_alu, is_lw, is_sw, is_beq, is_jump;
  assign is_alu  = (instr_reg[7:5] == 3'b000) || (instr_reg[7:5] == 3'b001);
  assign is_lw   = (instr_reg[7:5] == 3'b010);
  assign is_sw   = (instr_reg[7:5] == 3'b011);
  assign is_beq  = (instr_reg[7:5] == 3'b100);
  assign is_jump = (instr_reg[7:6] == 2'b11);

  logic waiting;
  assign waiting = (state_reg == S_FETCH) || (state_reg == S_MEM);

  // Next-state and control-pulse decode from current state and handshake inputs.
  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    alu_en     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_write  = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.run) state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_load    = 1'b1;
          state_next = S_DECODE;
        end else if (tmo_reg == TMO_LAST) begin
          state_next = S_FAULT;
        end
      end
      S_DECODE: begin
        state_next = S_EXEC;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if (is_alu) begin
          state_next = S_WB;
        end else if (is_lw || is_sw) begin
          state_next = S_MEM;
        end else begin
          // beq, jump and the reserved NOP all finish here
          if (is_jump || (is_beq && bus.alu_zero)) pc_load = 1'b1;
          else                                     pc_inc  = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (bus.dmem_ready) begin
          if (is_lw) begin
            state_next = S_WB;
          end else begin
            pc_inc     = 1'b1;
            state_next = S_FETCH;
          end
        end else if (tmo_reg == TMO_LAST) begin
          state_next = S_FAULT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_inc     = 1'b1;
        state_next = S_FETCH;
      end
      S_FAULT: begin
        state_next = S_FAULT;
      end
      default: begin
        state_next = S_FAULT;
      end
    endcase
  end

  // State, latched instruction, timeout counter and sticky fault flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      instr_reg <= 8'h00;
      tmo_reg   <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (ir_load) instr_reg <= bus.imem_rdata;
      if (state_next != state_reg) tmo_reg <= '0;
      else if (waiting)            tmo_reg <= tmo_reg + TW'(1);
      if (state_next == S_FAULT) fault_reg <= 1'b1;
    end
  end

  assign bus.imem_req  = imem_req;
  assign bus.ir_load   = ir_load;
  assign bus.alu_en    = alu_en;
  assign bus.dmem_req  = dmem_req;
  assign bus.dmem_we   = dmem_we;
  assign bus.reg_write = reg_write;
  assign bus.pc_inc    = pc_inc;
  assign bus.pc_load   = pc_load;
  assign bus.instr_out = instr_reg;
  assign bus.fault     = fault_reg;
  assign bus.state     = state_reg;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] retired_cnt_reg;

  // One retirement per PC update; pulses never fire in FAULT, so it freezes there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              retired_cnt_reg <= 16'h0000;
    else if (pc_inc || pc_load) retired_cnt_reg <= retired_cnt_reg + 16'd1;
  end

  assign bus.retired_cnt = retired_cnt_reg;
`endif

endmodule
